// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter and its
// round-robin picker.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 16;
    localparam int GNT_W    = $clog2(NREQ_DEF);

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping at NREQ. Kept generic so other resource arbiters can reuse it.
module rr_pick
    import mul_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    localparam int GW = $clog2(NREQ);

    always_comb begin
        int cand;
        cand  = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any_o && req_i[cand[GW-1:0]]) begin
                any_o                = 1'b1;
                idx_o                = cand[GW-1:0];
                gnt_o[cand[GW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one sequential multiplier core among NREQ requesters,
// with a watchdog that closes a transaction out if the core never finishes.
//
// state | meaning
// IDLE  | waiting for any req_valid; grants and latches operands on accept
// ISSUE | one-cycle mul_start pulse to the core, watchdog loaded
// BUSY  | waiting for mul_done while the watchdog counts down
// RESP  | result offered to the granted requester until its rsp_ready
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = 2 * W + 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid_i,
    output logic [NREQ-1:0]     req_ready_o,
    input  logic [NREQ*W-1:0]   req_a_i,
    input  logic [NREQ*W-1:0]   req_b_i,
    output logic [NREQ-1:0]     rsp_valid_o,
    input  logic [NREQ-1:0]     rsp_ready_i,
    output logic [2*W-1:0]      rsp_product_o,
    output logic                rsp_err_o,
    output logic                mul_start_o,
    output logic [W-1:0]        mul_a_o,
    output logic [W-1:0]        mul_b_o,
    input  logic                mul_done_i,
    input  logic [2*W-1:0]      mul_product_i,
    output logic                busy_o
);

    localparam int GW   = $clog2(NREQ);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Down-counter: loaded in ISSUE, terminal count at zero is the
    // TIMEOUT-th BUSY cycle.
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    arb_state_t        state_q;
    logic [GW-1:0]     rr_ptr_q;
    logic [GW-1:0]     rr_ptr_d;
    logic [GW-1:0]     grant_q;
    logic [NREQ-1:0]   gnt_oh_q;
    logic [WD_W-1:0]   wd_cnt_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [2*W-1:0]    rsp_product_q;
    logic              rsp_err_q;
    logic              mul_start_q;
    logic [W-1:0]      mul_a_q;
    logic [W-1:0]      mul_b_q;
    logic [W-1:0]      mul_a_d;
    logic [W-1:0]      mul_b_d;
    logic              busy_q;

    logic [NREQ-1:0]   pick_gnt;
    logic [GW-1:0]     pick_idx;
    logic              pick_any;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign req_ready_o = (state_q == IDLE) ? pick_gnt : '0;
    assign mul_a_d     = req_a_i[pick_idx*W +: W];
    assign mul_b_d     = req_b_i[pick_idx*W +: W];
    assign rr_ptr_d    = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            gnt_oh_q      <= '0;
            wd_cnt_q      <= '0;
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b0;
            mul_start_q   <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            busy_q        <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        mul_a_q     <= mul_a_d;
                        mul_b_q     <= mul_b_d;
                        grant_q     <= pick_idx;
                        gnt_oh_q    <= pick_gnt;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt_q <= WD_LOAD;
                    state_q  <= BUSY;
                end
                BUSY: begin
                    wd_cnt_q <= wd_cnt_q - 1'b1;
                    // A completion in the expiry cycle still counts as success.
                    if (mul_done_i) begin
                        rsp_product_q <= mul_product_i;
                        rsp_err_q     <= 1'b0;
                        rsp_valid_q   <= gnt_oh_q;
                        state_q       <= RESP;
                    end else if (wd_cnt_q == '0) begin
                        rsp_product_q <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_valid_q   <= gnt_oh_q;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i[grant_q]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_product_o = rsp_product_q;
    assign rsp_err_o     = rsp_err_q;
    assign mul_start_o   = mul_start_q;
    assign mul_a_o       = mul_a_q;
    assign mul_b_o       = mul_b_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed vector table, hand sequences for
// reset abort, and random traffic against a transaction-level model.
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TO   = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready = '0;
    logic [31:0] rsp_product;
    logic        rsp_err;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        busy;

    logic        core_done  = 1'b0;
    logic        stray_done = 1'b0;
    logic [31:0] core_prod  = '0;
    int          core_lat   = 34;
    int          core_cnt   = 0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  v;
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
        int          dly;
        int          gnt;
        logic [31:0] prod;
        logic        err;
    } vec_t;

    always #5 clk = ~clk;

    assign mul_done    = core_done | stray_done;
    assign mul_product = stray_done ? 32'hDEADBEEF : core_prod;

    mul_share_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_product_o (rsp_product),
        .rsp_err_o     (rsp_err),
        .mul_start_o   (mul_start),
        .mul_a_o       (mul_a),
        .mul_b_o       (mul_b),
        .mul_done_i    (mul_done),
        .mul_product_i (mul_product),
        .busy_o        (busy)
    );

    // Core model: done pulse core_lat cycles after the start cycle; 0 = hung.
    always @(negedge clk) begin
        logic signed [31:0] ca;
        logic signed [31:0] cb;
        core_done = 1'b0;
        if (!rst) begin
            core_cnt = 0;
        end else begin
            if (core_cnt > 0) begin
                core_cnt = core_cnt - 1;
                if (core_cnt == 0) core_done = 1'b1;
            end
            if (mul_start && core_lat > 0) begin
                core_cnt  = core_lat;
                ca        = 32'(signed'(mul_a));
                cb        = 32'(signed'(mul_b));
                core_prod = ca * cb;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                                input int lat, input int dly, input int gnt,
                                input logic [31:0] p, input logic e);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.lat = lat; r.dly = dly;
        r.gnt = gnt; r.prod = p; r.err = e;
        return r;
    endfunction

    // One full transaction, entered and left at posedge+1 with the arbiter idle.
    task automatic do_txn(input logic [3:0] v, input logic [63:0] aa, input logic [63:0] bb,
                          input int lat, input int dly, input int gnt,
                          input logic [31:0] prod, input logic err, input string nm);
        logic [3:0] oh;
        int         k;
        int         exp_k;
        logic       quiet;
        logic       hold;
        oh    = 4'b0001 << gnt;
        exp_k = (lat == 0 || lat > TO) ? TO + 1 : lat + 1;
        core_lat  = lat;
        req_valid = v;
        req_a     = aa;
        req_b     = bb;
        #1;
        check({nm, " req_ready"}, 64'(req_ready), 64'(oh));
        @(posedge clk); #1;
        req_valid = v & ~oh;
        check({nm, " issue"}, 64'({mul_start, busy, req_ready}), 64'({1'b1, 1'b1, 4'b0000}));
        check({nm, " mul_ab"}, 64'({mul_a, mul_b}), 64'({aa[gnt*16 +: 16], bb[gnt*16 +: 16]}));
        stray_done = 1'b1;
        quiet = 1'b1;
        k = 0;
        while (k < 100) begin
            @(posedge clk); #1;
            stray_done = 1'b0;
            k++;
            if (rsp_valid != '0) break;
            if (req_ready != '0 || mul_start || !busy) quiet = 1'b0;
        end
        check({nm, " quiet_busy"}, 64'(quiet), 64'(1));
        check({nm, " rsp_latency"}, 64'(k), 64'(exp_k));
        check({nm, " rsp_valid"}, 64'(rsp_valid), 64'(oh));
        check({nm, " rsp_product"}, 64'(rsp_product), 64'(prod));
        check({nm, " rsp_err"}, 64'(rsp_err), 64'(err));
        stray_done = 1'b1;
        rsp_ready  = ~oh;
        hold = 1'b1;
        for (int d = 0; d < dly; d++) begin
            @(posedge clk); #1;
            stray_done = 1'b0;
            if (rsp_valid != oh || rsp_product != prod || rsp_err != err || !busy ||
                req_ready != '0 || mul_start) hold = 1'b0;
        end
        check({nm, " resp_hold"}, 64'(hold), 64'(1));
        rsp_ready = oh;
        @(posedge clk); #1;
        stray_done = 1'b0;
        rsp_ready  = '0;
        check({nm, " release"}, 64'({busy, rsp_valid, mul_a}), 64'({1'b0, 4'b0000, aa[gnt*16 +: 16]}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t               tbl[$];
        logic [63:0]        aa;
        logic [63:0]        bb;
        logic [3:0]         pend;
        logic [15:0]        pa [4];
        logic [15:0]        pb [4];
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        ep;
        int                 g;
        int                 lat;
        int                 mptr;

        #1;
        check("reset ctl", 64'({rsp_valid, req_ready, rsp_err, mul_start, busy}), 64'(0));
        check("reset data", 64'({rsp_product, mul_a, mul_b}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        tbl.push_back(mk(4'b1111, 16'h0002, 16'h0003, 34, 0, 0, 32'h0000_0006, 1'b0));
        tbl.push_back(mk(4'b1111, 16'hFFFF, 16'hFFFF, 10, 0, 1, 32'h0000_0001, 1'b0));
        tbl.push_back(mk(4'b1111, 16'h0100, 16'h0100, 34, 5, 2, 32'h0001_0000, 1'b0));
        tbl.push_back(mk(4'b1111, 16'h1234, 16'h0000,  1, 0, 3, 32'h0000_0000, 1'b0));
        tbl.push_back(mk(4'b1111, 16'hFFFE, 16'h0003, 20, 1, 0, 32'hFFFF_FFFA, 1'b0));
        tbl.push_back(mk(4'b1010, 16'h0010, 16'hFFF0, 34, 0, 1, 32'hFFFF_FF00, 1'b0));
        tbl.push_back(mk(4'b1010, 16'h7FFF, 16'h7FFF,  3, 0, 3, 32'h3FFF_0001, 1'b0));
        tbl.push_back(mk(4'b0001, 16'h0003, 16'h0005, 34, 0, 0, 32'h0000_000F, 1'b0));
        tbl.push_back(mk(4'b0100, 16'hFFF9, 16'h0006, 34, 0, 2, 32'hFFFF_FFD6, 1'b0));
        tbl.push_back(mk(4'b0010, 16'h0005, 16'h0005, 40, 0, 1, 32'h0000_0019, 1'b0));
        tbl.push_back(mk(4'b1000, 16'h1111, 16'h0002,  0, 2, 3, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(4'b0001, 16'h8000, 16'h8000,  5, 0, 0, 32'h4000_0000, 1'b0));
        tbl.push_back(mk(4'b1001, 16'h7FFF, 16'h8000,  2, 0, 3, 32'hC000_8000, 1'b0));
        tbl.push_back(mk(4'b0011, 16'h0002, 16'hFFFF, 39, 3, 0, 32'hFFFF_FFFE, 1'b0));

        foreach (tbl[i]) begin
            aa = {$urandom, $urandom};
            bb = {$urandom, $urandom};
            aa[tbl[i].gnt*16 +: 16] = tbl[i].a;
            bb[tbl[i].gnt*16 +: 16] = tbl[i].b;
            do_txn(tbl[i].v, aa, bb, tbl[i].lat, tbl[i].dly, tbl[i].gnt,
                   tbl[i].prod, tbl[i].err, $sformatf("vec%0d", i));
        end

        // Reset in the middle of BUSY aborts without a response.
        core_lat  = 34;
        req_a     = 64'h0000_1234_0000_0000;
        req_b     = 64'h0000_5678_0000_0000;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort pre_busy", 64'({busy, mul_a}), 64'({1'b1, 16'h1234}));
        rst = 1'b0;
        #1;
        check("abort ctl", 64'({rsp_valid, req_ready, rsp_err, mul_start, busy}), 64'(0));
        check("abort data", 64'({rsp_product, mul_a, mul_b}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        do_txn(4'b0010, 64'h0000_0000_0002_0000, 64'h0000_0000_0002_0000,
               34, 0, 1, 32'h0000_0004, 1'b0, "post_rst");

        // Random traffic: requesters hold their request until granted.
        mptr = 2;
        pend = '0;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pa[i]   = 16'($urandom);
                    pb[i]   = 16'($urandom);
                end
            end
            if (pend == '0) begin
                g       = $urandom_range(0, NREQ - 1);
                pend[g] = 1'b1;
                pa[g]   = 16'($urandom);
                pb[g]   = 16'($urandom);
            end
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && pend[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            end
            lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
            if (lat == 0) begin
                ep = '0;
            end else begin
                sa = 32'(signed'(pa[g]));
                sb = 32'(signed'(pb[g]));
                ep = sa * sb;
            end
            aa = {pa[3], pa[2], pa[1], pa[0]};
            bb = {pb[3], pb[2], pb[1], pb[0]};
            do_txn(pend, aa, bb, lat, $urandom_range(0, 3), g, ep, (lat == 0),
                   $sformatf("rnd%0d", t));
            pend[g] = 1'b0;
            mptr    = (g + 1) % NREQ;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
